// File: rtl/alu_sequencer.sv
// Multi-cycle issue/control block for a 32-bit ALU: decodes instruction words,
// drives registered operands, waits ALU_WAIT cycles, then writes back or resolves beq.
module alu_sequencer #(
  parameter int ALU_WAIT = 1,
  parameter int NREGS    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [31:0] ALU_DATA1,
  output logic [31:0] ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_ZERO,
  output logic        DONE,
  output logic        ILLEGAL,
  output logic        BRANCH_TAKEN,
  output logic [7:0]  BRANCH_OFFSET,
  input  logic [2:0]  DBG_ADDR,
  output logic [31:0] DBG_DATA
);

  localparam int DATA_W = 32;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              issue, retire;
  logic [DATA_W-1:0] rf [NREGS];

  logic [7:0]        op_p0;
  logic [2:0]        rd_p0, rs1_p0, rs2_p0;
  logic [2:0]        sel_p0;
  logic [DATA_W-1:0] d1_p0, d2_p0;
  logic              wr_p0, beq_p0, ill_p0;

  logic [2:0]        rd_p1;
  logic              wr_p1, beq_p1, ill_p1;
  logic signed [7:0] off_p1;

  logic              unused_instr_bits;

  assign unused_instr_bits = ^INSTR[15:11];
  assign DBG_DATA          = rf[DBG_ADDR];

  // ---- p0: decode straight off the instruction bus ----
  always_comb begin
    op_p0  = INSTR[31:24];
    rd_p0  = INSTR[18:16];
    rs1_p0 = INSTR[10:8];
    rs2_p0 = INSTR[2:0];
    sel_p0 = 3'b111;
    d1_p0  = '0;
    d2_p0  = '0;
    wr_p0  = 1'b0;
    beq_p0 = 1'b0;
    ill_p0 = 1'b0;
    case (op_p0)
      8'h00: begin
        sel_p0 = 3'b100;
        d2_p0  = {24'h0, INSTR[7:0]};
        wr_p0  = 1'b1;
      end
      8'h01: begin
        sel_p0 = 3'b100;
        d2_p0  = rf[rs2_p0];
        wr_p0  = 1'b1;
      end
      8'h02, 8'h03, 8'h04, 8'h05: begin
        d1_p0 = rf[rs1_p0];
        d2_p0 = rf[rs2_p0];
        wr_p0 = 1'b1;
        case (op_p0[2:0])
          3'd2:    sel_p0 = 3'b000;
          3'd3:    sel_p0 = 3'b001;
          3'd4:    sel_p0 = 3'b010;
          default: sel_p0 = 3'b011;
        endcase
      end
      8'h07: begin
        // beq compares via subtraction and reads the ALU zero flag
        sel_p0 = 3'b001;
        d1_p0  = rf[rs1_p0];
        d2_p0  = rf[rs2_p0];
        beq_p0 = 1'b1;
      end
      default: ill_p0 = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    INSTR_READY = 1'b0;
    issue       = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: begin
        INSTR_READY = !RESET;
        if (INSTR_VALID && !RESET) begin
          issue   = 1'b1;
          cnt_d   = 4'(ALU_WAIT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- p1: operands registered at handshake, retire after the wait ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ALU_DATA1     <= '0;
      ALU_DATA2     <= '0;
      ALU_SELECT    <= 3'b000;
      DONE          <= 1'b0;
      ILLEGAL       <= 1'b0;
      BRANCH_TAKEN  <= 1'b0;
      BRANCH_OFFSET <= '0;
      rd_p1         <= '0;
      wr_p1         <= 1'b0;
      beq_p1        <= 1'b0;
      ill_p1        <= 1'b0;
      off_p1        <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      DONE         <= retire;
      ILLEGAL      <= retire && ill_p1;
      BRANCH_TAKEN <= retire && beq_p1 && ALU_ZERO;
      if (issue) begin
        ALU_DATA1  <= d1_p0;
        ALU_DATA2  <= d2_p0;
        ALU_SELECT <= sel_p0;
        rd_p1      <= rd_p0;
        wr_p1      <= wr_p0;
        beq_p1     <= beq_p0;
        ill_p1     <= ill_p0;
        off_p1     <= INSTR[23:16];
      end
      if (retire && beq_p1) BRANCH_OFFSET <= off_p1;
      if (retire && wr_p1) rf[rd_p1] <= ALU_RESULT;
    end
  end

endmodule
